// File: rtl/rv32i_memory_stage_pkg.sv
// Shared definitions for the RV32I memory stage: opcode/exception indices,
// funct3 size encodings, FSM state type and the alignment helper.
package rv32i_memory_stage_pkg;

    localparam int OPCODE_WIDTH    = 11;
    localparam int EXCEPTION_WIDTH = 6;

    // One-hot opcode bit positions
    localparam int RTYPE  = 0;
    localparam int ITYPE  = 1;
    localparam int LOAD   = 2;
    localparam int STORE  = 3;
    localparam int BRANCH = 4;
    localparam int JAL    = 5;
    localparam int JALR   = 6;
    localparam int LUI    = 7;
    localparam int AUIPC  = 8;
    localparam int SYSTEM = 9;
    localparam int FENCE  = 10;

    localparam int EXC_ILLEGAL          = 0;
    localparam int EXC_ECALL            = 1;
    localparam int EXC_EBREAK           = 2;
    localparam int EXC_MRET             = 3;
    localparam int EXC_LOAD_MISALIGNED  = 4;
    localparam int EXC_STORE_MISALIGNED = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Halfwords need y[0]=0, words need y[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_mem_lane_align.sv
// Byte-lane steering: store sel/replicated data and load extract/extend.
// Purely combinational.
module rv32i_mem_lane_align
    import rv32i_memory_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  sel,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        shifted  = load_word >> {offset, 3'b000};
        byte_val = shifted[7:0];
        half_val = offset[1] ? load_word[31:16] : load_word[15:0];

        case (funct3[1:0])
            2'b00: begin
                sel        = 4'b0001 << offset;
                store_word = {4{store_data[7:0]}};
            end
            2'b01: begin
                sel        = 4'b0011 << {offset[1], 1'b0};
                store_word = {2{store_data[15:0]}};
            end
            default: begin
                sel        = 4'b1111;
                store_word = store_data;
            end
        endcase

        case (funct3)
            F3_LB:   load_data = {{24{byte_val[7]}}, byte_val};
            F3_LH:   load_data = {{16{half_val[15]}}, half_val};
            F3_LBU:  load_data = {24'd0, byte_val};
            F3_LHU:  load_data = {16'd0, half_val};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/rv32i_memory_stage.sv
// RV32I memory stage: pipelined Wishbone load/store with pipeline stall.
// Optional misaligned-access trapping under `MEM_MISALIGN_CHECK_EN.
// Handshake: an instruction is taken when i_ce=1 and o_stall=0 (and no flush);
// o_ce=1 offers a result downstream, held while i_stall=1.
module rv32i_memory_stage
    import rv32i_memory_stage_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [31:0]                i_y,
    input  logic [31:0]                i_rs2,
    input  logic [2:0]                 i_funct3,
    input  logic [OPCODE_WIDTH-1:0]    i_opcode,
    input  logic [EXCEPTION_WIDTH-1:0] i_exception,
    input  logic [31:0]                i_pc,
    input  logic [4:0]                 i_rd_addr,
    input  logic [31:0]                i_rd,
    input  logic                       i_wr_rd,
    input  logic                       i_ce,
    input  logic                       i_stall,
    input  logic                       i_flush,
    output logic                       o_wb_cyc,
    output logic                       o_wb_stb,
    output logic                       o_wb_we,
    output logic [31:0]                o_wb_addr,
    output logic [31:0]                o_wb_data,
    output logic [3:0]                 o_wb_sel,
    input  logic                       i_wb_ack,
    input  logic                       i_wb_stall,
    input  logic [31:0]                i_wb_data,
    output logic [4:0]                 o_rd_addr,
    output logic [31:0]                o_rd,
    output logic                       o_wr_rd,
    output logic [2:0]                 o_funct3,
    output logic [OPCODE_WIDTH-1:0]    o_opcode,
    output logic [31:0]                o_pc,
    output logic [EXCEPTION_WIDTH-1:0] o_exception,
    output logic                       o_ce,
    output logic                       o_stall_from_mem,
    output logic                       o_stall,
    output logic                       o_flush,
    output state_t                     o_state
);

    logic                       is_load, is_store, is_mem, accept, bus_done, kill;
    logic                       is_load_q, wr_rd_q, discard_q;
    logic [1:0]                 addr_lo_q;
    logic [2:0]                 lane_f3;
    logic [1:0]                 lane_off;
    logic [3:0]                 lane_sel;
    logic [31:0]                lane_wdata, lane_rdata;
    logic [EXCEPTION_WIDTH-1:0] misalign_bits;

    assign is_load          = i_opcode[LOAD];
    assign is_store         = i_opcode[STORE];
    assign is_mem           = is_load | is_store;
    assign o_stall_from_mem = (o_state != S_IDLE);
    assign o_stall          = i_stall | o_stall_from_mem;
    assign accept           = i_ce & ~o_stall & ~i_flush;
    assign bus_done         = i_wb_ack & (((o_state == S_REQ) & ~i_wb_stall) | (o_state == S_WAIT));
    assign kill             = discard_q | i_flush;

    always_comb begin
        misalign_bits = '0;
`ifdef MEM_MISALIGN_CHECK_EN
        if (is_mem && is_misaligned(i_funct3, i_y[1:0])) begin
            misalign_bits[EXC_LOAD_MISALIGNED]  = is_load;
            misalign_bits[EXC_STORE_MISALIGNED] = is_store;
        end
`endif
    end

    // Store steering is only needed while idle; load extraction only during an access.
    assign lane_f3  = (o_state == S_IDLE) ? i_funct3 : o_funct3;
    assign lane_off = (o_state == S_IDLE) ? i_y[1:0] : addr_lo_q;

    rv32i_mem_lane_align u_lane_align (
        .funct3     (lane_f3),
        .offset     (lane_off),
        .store_data (i_rs2),
        .load_word  (i_wb_data),
        .sel        (lane_sel),
        .store_word (lane_wdata),
        .load_data  (lane_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_state     <= S_IDLE;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
            o_wb_sel    <= '0;
            o_rd_addr   <= '0;
            o_rd        <= '0;
            o_wr_rd     <= 1'b0;
            o_funct3    <= '0;
            o_opcode    <= '0;
            o_pc        <= '0;
            o_exception <= '0;
            o_ce        <= 1'b0;
            o_flush     <= 1'b0;
            is_load_q   <= 1'b0;
            wr_rd_q     <= 1'b0;
            discard_q   <= 1'b0;
            addr_lo_q   <= '0;
        end else begin
            o_flush <= i_flush;
            case (o_state)
                S_IDLE: begin
                    if (accept) begin
                        o_rd_addr   <= i_rd_addr;
                        o_funct3    <= i_funct3;
                        o_opcode    <= i_opcode;
                        o_pc        <= i_pc;
                        o_exception <= i_exception | misalign_bits;
                        if (misalign_bits != '0) begin
                            o_rd    <= i_rd;
                            o_ce    <= 1'b1;
                            o_wr_rd <= 1'b0;
                        end else if (is_mem) begin
                            o_state   <= S_REQ;
                            o_wb_cyc  <= 1'b1;
                            o_wb_stb  <= 1'b1;
                            o_wb_we   <= is_store;
                            o_wb_addr <= {i_y[31:2], 2'b00};
                            o_wb_data <= lane_wdata;
                            o_wb_sel  <= lane_sel;
                            addr_lo_q <= i_y[1:0];
                            is_load_q <= is_load;
                            wr_rd_q   <= is_load & i_wr_rd;
                            discard_q <= 1'b0;
                            o_ce      <= 1'b0;
                            o_wr_rd   <= 1'b0;
                        end else begin
                            o_rd    <= i_rd;
                            o_ce    <= 1'b1;
                            o_wr_rd <= i_wr_rd;
                        end
                    end else if (i_flush || !i_stall) begin
                        o_ce    <= 1'b0;
                        o_wr_rd <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (i_flush) discard_q <= 1'b1;
                    if (!i_wb_stall) begin
                        o_wb_stb <= 1'b0;
                        o_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_flush) discard_q <= 1'b1;
                end
                default: o_state <= S_IDLE;
            endcase

            // Completion overrides the REQ->WAIT move when ack coincides with acceptance.
            if (bus_done) begin
                o_state  <= S_IDLE;
                o_wb_cyc <= 1'b0;
                o_wb_stb <= 1'b0;
                o_rd     <= is_load_q ? lane_rdata : 32'd0;
                o_ce     <= ~kill;
                o_wr_rd  <= wr_rd_q & ~kill;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_memory_stage.sv
// Directed self-checking bench for rv32i_memory_stage.
module tb_rv32i_memory_stage;
  import rv32i_memory_stage_pkg::*;

  logic                       i_clk, i_rst_n;
  logic [31:0]                i_y, i_rs2, i_pc, i_rd, i_wb_data;
  logic [2:0]                 i_funct3;
  logic [OPCODE_WIDTH-1:0]    i_opcode;
  logic [EXCEPTION_WIDTH-1:0] i_exception;
  logic [4:0]                 i_rd_addr;
  logic                       i_wr_rd, i_ce, i_stall, i_flush, i_wb_ack, i_wb_stall;
  logic                       o_wb_cyc, o_wb_stb, o_wb_we, o_wr_rd, o_ce;
  logic                       o_stall_from_mem, o_stall, o_flush;
  logic [31:0]                o_wb_addr, o_wb_data, o_rd, o_pc;
  logic [3:0]                 o_wb_sel;
  logic [4:0]                 o_rd_addr;
  logic [2:0]                 o_funct3;
  logic [OPCODE_WIDTH-1:0]    o_opcode;
  logic [EXCEPTION_WIDTH-1:0] o_exception;
  state_t                     o_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tb_pc = 32'h0000_0100;

  rv32i_memory_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_y(i_y), .i_rs2(i_rs2), .i_funct3(i_funct3),
    .i_opcode(i_opcode), .i_exception(i_exception), .i_pc(i_pc), .i_rd_addr(i_rd_addr),
    .i_rd(i_rd), .i_wr_rd(i_wr_rd), .i_ce(i_ce), .i_stall(i_stall), .i_flush(i_flush),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
    .i_wb_data(i_wb_data), .o_rd_addr(o_rd_addr), .o_rd(o_rd), .o_wr_rd(o_wr_rd),
    .o_funct3(o_funct3), .o_opcode(o_opcode), .o_pc(o_pc), .o_exception(o_exception),
    .o_ce(o_ce), .o_stall_from_mem(o_stall_from_mem), .o_stall(o_stall), .o_flush(o_flush),
    .o_state(o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Presents one instruction for one edge; returns at the following negedge.
  task automatic issue(input int op_idx, input logic [2:0] f3, input logic [31:0] y,
                       input logic [31:0] rs2, input logic [31:0] rd, input logic [4:0] rd_addr,
                       input logic wr);
    i_opcode = '0;
    i_opcode[op_idx] = 1'b1;
    i_funct3 = f3; i_y = y; i_rs2 = rs2; i_rd = rd; i_rd_addr = rd_addr; i_wr_rd = wr;
    i_pc = tb_pc; tb_pc = tb_pc + 32'd4;
    i_ce = 1'b1;
    tick();
    i_ce = 1'b0;
  endtask

  // Slave model: holds i_wb_stall for stall_n strobe cycles, waits wait_n cycles, then acks.
  task automatic serve(input int stall_n, input int wait_n, input logic [31:0] rdata,
                       output int stb_cnt, output int stall_low);
    int guard;
    int s;
    stb_cnt = 0; stall_low = 0; guard = 0; s = stall_n;
    while (o_wb_stb && guard < 40) begin
      stb_cnt++;
      if (!o_stall_from_mem) stall_low++;
      i_wb_stall = (s > 0);
      if (s > 0) s--;
      tick();
      guard++;
    end
    i_wb_stall = 1'b0;
    for (int w = 0; w < wait_n; w++) begin
      if (!o_stall_from_mem) stall_low++;
      tick();
    end
    if (!o_stall_from_mem) stall_low++;
    i_wb_ack = 1'b1; i_wb_data = rdata;
    tick();
    i_wb_ack = 1'b0; i_wb_data = '0;
  endtask

  // test tasks
  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (o_ce !== 1'b0 || o_rd !== 32'd0 || o_wr_rd !== 1'b0) begin failures++; $display("FAIL reset_out got ce=%b rd=%h wr=%b exp 0/0/0", o_ce, o_rd, o_wr_rd); end
    checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_stall_from_mem !== 1'b0) begin failures++; $display("FAIL reset_bus got cyc=%b stb=%b stall=%b exp 0", o_wb_cyc, o_wb_stb, o_stall_from_mem); end
    checks++; if (o_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", o_state, S_IDLE); end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pass_through();
    logic [31:0] pc_exp;
    pc_exp = tb_pc;
    issue(RTYPE, 3'b000, 32'h0000_0044, 32'd0, 32'h0000_1234, 5'd5, 1'b1);
    checks++; if (o_rd !== 32'h0000_1234 || o_ce !== 1'b1) begin failures++; $display("FAIL pass_rd got rd=%h ce=%b exp rd=00001234 ce=1", o_rd, o_ce); end
    checks++; if (o_wr_rd !== 1'b1 || o_rd_addr !== 5'd5 || o_pc !== pc_exp) begin failures++; $display("FAIL pass_fields got wr=%b addr=%0d pc=%h exp 1/5/%h", o_wr_rd, o_rd_addr, o_pc, pc_exp); end
    checks++; if (o_wb_cyc !== 1'b0 || o_state !== S_IDLE) begin failures++; $display("FAIL pass_nobus got cyc=%b state=%0d exp 0/0", o_wb_cyc, o_state); end
    tick();
    checks++; if (o_ce !== 1'b0) begin failures++; $display("FAIL pass_bubble got ce=%b exp 0", o_ce); end
  endtask

  task automatic test_stores();
    int stb_cnt, stall_low;
    issue(STORE, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'd0, 5'd3, 1'b1);
    checks++; if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b1 || o_wb_we !== 1'b1 || o_stall_from_mem !== 1'b1) begin failures++; $display("FAIL sb_req got cyc=%b stb=%b we=%b stall=%b exp 1111", o_wb_cyc, o_wb_stb, o_wb_we, o_stall_from_mem); end
    checks++; if (o_wb_sel !== 4'b1000 || o_wb_data !== 32'hABAB_ABAB || o_wb_addr !== 32'h0000_1000) begin failures++; $display("FAIL sb_lanes got sel=%b data=%h addr=%h exp 1000/ababab ab/00001000", o_wb_sel, o_wb_data, o_wb_addr); end
    serve(0, 0, 32'd0, stb_cnt, stall_low);
    checks++; if (o_ce !== 1'b1 || o_wr_rd !== 1'b0 || o_wb_cyc !== 1'b0 || o_stall_from_mem !== 1'b0) begin failures++; $display("FAIL sb_done got ce=%b wr=%b cyc=%b stall=%b exp 1/0/0/0", o_ce, o_wr_rd, o_wb_cyc, o_stall_from_mem); end
    checks++; if (stb_cnt != 1 || stall_low != 0) begin failures++; $display("FAIL sb_timing got stb_cycles=%0d stall_low=%0d exp 1/0", stb_cnt, stall_low); end
    issue(STORE, 3'b001, 32'h0000_1002, 32'h1234_ABCD, 32'd0, 5'd0, 1'b0);
    checks++; if (o_wb_sel !== 4'b1100 || o_wb_data !== 32'hABCD_ABCD || o_wb_addr !== 32'h0000_1000) begin failures++; $display("FAIL sh_lanes got sel=%b data=%h addr=%h exp 1100/abcdabcd/00001000", o_wb_sel, o_wb_data, o_wb_addr); end
    serve(0, 0, 32'd0, stb_cnt, stall_low);
    issue(STORE, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, 32'd0, 5'd0, 1'b0);
    checks++; if (o_wb_sel !== 4'b1111 || o_wb_data !== 32'hCAFE_F00D || o_wb_addr !== 32'h0000_2000) begin failures++; $display("FAIL sw_lanes got sel=%b data=%h addr=%h exp 1111/cafef00d/00002000", o_wb_sel, o_wb_data, o_wb_addr); end
    serve(0, 0, 32'd0, stb_cnt, stall_low);
    tick();
  endtask

  logic [2:0]  ld_f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
  logic [31:0] ld_y   [6] = '{32'h2002, 32'h2002, 32'h2002, 32'h2006, 32'h2004, 32'h2001};
  logic [31:0] ld_word[6] = '{32'h0080FF00, 32'h0080FF00, 32'h80010000, 32'h80010000, 32'hDEADBEEF, 32'h00007F00};
  logic [31:0] ld_exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hDEADBEEF, 32'h0000007F};

  task automatic test_loads();
    int stb_cnt, stall_low;
    for (int i = 0; i < 6; i++) begin
      issue(LOAD, ld_f3[i], ld_y[i], 32'd0, 32'hFFFF_FFFF, 5'(i + 1), 1'b1);
      serve(0, (i < 2) ? 2 : 0, ld_word[i], stb_cnt, stall_low);
      checks++; if (o_rd !== ld_exp[i] || o_ce !== 1'b1) begin failures++; $display("FAIL load_data[%0d] got rd=%h ce=%b exp rd=%h ce=1", i, o_rd, o_ce, ld_exp[i]); end
      checks++; if (o_wr_rd !== 1'b1 || o_rd_addr !== 5'(i + 1) || o_funct3 !== ld_f3[i]) begin failures++; $display("FAIL load_fields[%0d] got wr=%b addr=%0d f3=%b exp 1/%0d/%b", i, o_wr_rd, o_rd_addr, o_funct3, i + 1, ld_f3[i]); end
      checks++; if (stall_low != 0 || stb_cnt != 1 || o_stall_from_mem !== 1'b0) begin failures++; $display("FAIL load_stall[%0d] got stall_low=%0d stb=%0d stall_now=%b exp 0/1/0", i, stall_low, stb_cnt, o_stall_from_mem); end
      tick();
    end
  endtask

  task automatic test_bus_stall();
    int stb_cnt, stall_low;
    issue(LOAD, 3'b010, 32'h0000_0030, 32'd0, 32'd0, 5'd9, 1'b1);
    serve(3, 0, 32'h0BAD_F00D, stb_cnt, stall_low);
    checks++; if (stb_cnt != 4) begin failures++; $display("FAIL busstall_stb got=%0d exp=4", stb_cnt); end
    checks++; if (o_ce !== 1'b1 || o_rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL busstall_done got ce=%b rd=%h exp 1/0badf00d", o_ce, o_rd); end
    tick();
    checks++; if (o_ce !== 1'b0 || o_wb_cyc !== 1'b0) begin failures++; $display("FAIL busstall_single got ce=%b cyc=%b exp 0/0", o_ce, o_wb_cyc); end
  endtask

  task automatic test_flush();
    int stb_cnt, stall_low;
    i_flush = 1'b1;
    issue(LOAD, 3'b010, 32'h0000_0080, 32'd0, 32'd0, 5'd4, 1'b1);
    i_flush = 1'b0;
    checks++; if (o_wb_cyc !== 1'b0 || o_ce !== 1'b0 || o_flush !== 1'b1) begin failures++; $display("FAIL flush_preissue got cyc=%b ce=%b flush=%b exp 0/0/1", o_wb_cyc, o_ce, o_flush); end
    issue(LOAD, 3'b010, 32'h0000_0040, 32'd0, 32'd0, 5'd6, 1'b1);
    tick();
    checks++; if (o_state !== S_WAIT || o_wb_stb !== 1'b0 || o_wb_cyc !== 1'b1) begin failures++; $display("FAIL flush_wait got state=%0d stb=%b cyc=%b exp 2/0/1", o_state, o_wb_stb, o_wb_cyc); end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_wb_ack = 1'b1; i_wb_data = 32'h7777_7777;
    tick();
    i_wb_ack = 1'b0;
    checks++; if (o_ce !== 1'b0 || o_wr_rd !== 1'b0 || o_wb_cyc !== 1'b0) begin failures++; $display("FAIL flush_discard got ce=%b wr=%b cyc=%b exp 0/0/0", o_ce, o_wr_rd, o_wb_cyc); end
    issue(LOAD, 3'b010, 32'h0000_0044, 32'd0, 32'd0, 5'd7, 1'b1);
    serve(0, 0, 32'h1122_3344, stb_cnt, stall_low);
    checks++; if (o_ce !== 1'b1 || o_rd !== 32'h1122_3344 || o_wr_rd !== 1'b1) begin failures++; $display("FAIL flush_next got ce=%b rd=%h wr=%b exp 1/11223344/1", o_ce, o_rd, o_wr_rd); end
    tick();
  endtask

  task automatic test_downstream_stall();
    int stb_cnt, stall_low;
    i_stall = 1'b1;
    issue(RTYPE, 3'b000, 32'd0, 32'd0, 32'h0000_0099, 5'd1, 1'b1);
    checks++; if (o_ce !== 1'b0 || o_stall !== 1'b1) begin failures++; $display("FAIL dstall_block got ce=%b stall=%b exp 0/1", o_ce, o_stall); end
    i_stall = 1'b0;
    issue(RTYPE, 3'b000, 32'd0, 32'd0, 32'h0000_0055, 5'd1, 1'b1);
    i_stall = 1'b1;
    issue(RTYPE, 3'b000, 32'd0, 32'd0, 32'h0000_0066, 5'd2, 1'b1);
    checks++; if (o_ce !== 1'b1 || o_rd !== 32'h0000_0055 || o_rd_addr !== 5'd1) begin failures++; $display("FAIL dstall_hold got ce=%b rd=%h addr=%0d exp 1/00000055/1", o_ce, o_rd, o_rd_addr); end
    i_stall = 1'b0;
    tick();
    checks++; if (o_ce !== 1'b0) begin failures++; $display("FAIL dstall_release got ce=%b exp 0", o_ce); end
    issue(LOAD, 3'b010, 32'h0000_0050, 32'd0, 32'd0, 5'd8, 1'b1);
    i_stall = 1'b1;
    serve(0, 1, 32'hA5A5_0001, stb_cnt, stall_low);
    checks++; if (o_ce !== 1'b1 || o_rd !== 32'hA5A5_0001) begin failures++; $display("FAIL dstall_inflight got ce=%b rd=%h exp 1/a5a50001", o_ce, o_rd); end
    tick();
    checks++; if (o_ce !== 1'b1 || o_rd !== 32'hA5A5_0001 || o_wb_cyc !== 1'b0) begin failures++; $display("FAIL dstall_inflight_hold got ce=%b rd=%h cyc=%b exp 1/a5a50001/0", o_ce, o_rd, o_wb_cyc); end
    i_stall = 1'b0;
    tick();
    checks++; if (o_ce !== 1'b0) begin failures++; $display("FAIL dstall_inflight_release got ce=%b exp 0", o_ce); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[4] = '{32'h0000_0001, 32'hFFFF_0000, 32'h1357_9BDF, 32'h8000_0000};
    logic [31:0] exp_v;
    i_opcode = '0; i_opcode[ITYPE] = 1'b1; i_wr_rd = 1'b1; i_rd_addr = 5'd10;
    i_ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_rd = vals[i];
      @(posedge i_clk);
      exp_q.push_back(vals[i]);
      @(negedge i_clk);
      exp_v = exp_q.pop_front();
      checks++; if (o_ce !== 1'b1 || o_rd !== exp_v) begin failures++; $display("FAIL b2b[%0d] got ce=%b rd=%h exp 1/%h", i, o_ce, o_rd, exp_v); end
    end
    i_ce = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    issue(LOAD, 3'b010, 32'h0000_0060, 32'd0, 32'd0, 5'd2, 1'b1);
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin failures++; $display("FAIL rst_mid_drop got cyc=%b stb=%b exp 0/0", o_wb_cyc, o_wb_stb); end
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_wb_ack = 1'b1; i_wb_data = 32'hDEAD_0000;
    tick();
    i_wb_ack = 1'b0;
    checks++; if (o_ce !== 1'b0 || o_state !== S_IDLE || o_wb_cyc !== 1'b0) begin failures++; $display("FAIL rst_mid_ack got ce=%b state=%0d cyc=%b exp 0/0/0", o_ce, o_state, o_wb_cyc); end
  endtask

`ifdef MEM_MISALIGN_CHECK_EN
  task automatic test_misaligned();
    issue(LOAD, 3'b010, 32'h0000_3002, 32'd0, 32'd0, 5'd3, 1'b1);
    checks++; if (o_wb_cyc !== 1'b0 || o_stall_from_mem !== 1'b0) begin failures++; $display("FAIL misalign_nobus got cyc=%b stall=%b exp 0/0", o_wb_cyc, o_stall_from_mem); end
    checks++; if (o_ce !== 1'b1 || o_wr_rd !== 1'b0 || o_exception[EXC_LOAD_MISALIGNED] !== 1'b1) begin failures++; $display("FAIL misalign_exc got ce=%b wr=%b exc=%b exp 1/0/load bit set", o_ce, o_wr_rd, o_exception); end
    issue(STORE, 3'b001, 32'h0000_3001, 32'd0, 32'd0, 5'd0, 1'b0);
    checks++; if (o_wb_cyc !== 1'b0 || o_exception[EXC_STORE_MISALIGNED] !== 1'b1) begin failures++; $display("FAIL misalign_store got cyc=%b exc=%b exp 0/store bit set", o_wb_cyc, o_exception); end
    tick();
  endtask
`else
  task automatic test_misaligned();
    int stb_cnt, stall_low;
    issue(STORE, 3'b010, 32'h0000_3002, 32'h1111_2222, 32'd0, 5'd0, 1'b0);
    checks++; if (o_wb_addr !== 32'h0000_3000 || o_wb_sel !== 4'b1111 || o_wb_data !== 32'h1111_2222) begin failures++; $display("FAIL misalign_trunc got addr=%h sel=%b data=%h exp 00003000/1111/11112222", o_wb_addr, o_wb_sel, o_wb_data); end
    serve(0, 0, 32'd0, stb_cnt, stall_low);
    checks++; if (o_ce !== 1'b1 || o_exception !== '0) begin failures++; $display("FAIL misalign_done got ce=%b exc=%b exp 1/0", o_ce, o_exception); end
    tick();
  endtask
`endif

  initial begin
    i_rst_n = 1'b0; i_ce = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = '0;
    i_y = '0; i_rs2 = '0; i_funct3 = '0; i_opcode = '0; i_exception = '0;
    i_pc = '0; i_rd_addr = '0; i_rd = '0; i_wr_rd = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_pass_through();
    test_stores();
    test_loads();
    test_bus_stall();
    test_flush();
    test_downstream_stall();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
